univ_rotate_reg: RTL

Parametrised universal rotate/shift register, the next generation of our right-rotate register. It supports right or left direction, rotate/logical/arithmetic modes, single-step shifting, and a counted multi-position operation with a busy/done handshake. It sits in the register library as a drop-in datapath element for serializers, CRC/scrambler prep, and bit-alignment logic.

---
 rtl/univ_rotate_reg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/univ_rotate_reg.sv
// Purpose: universal rotate/shift register (rotate/logical/arithmetic, left/right) with single-step and counted operation.
// Latency: load/en take effect on the next edge; counted op of N>0 runs N cycles (one edge with UNIV_ROTATE_BARREL_EN), done pulses after the last step.
// Backpressure: none; start/en are ignored while busy, load aborts a running operation. Optional macro: UNIV_ROTATE_BARREL_EN.
module univ_rotate_reg #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          load,
  input  logic [DW-1:0] data,
  input  logic          en,
  input  logic          start,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  input  logic [1:0]    mode,
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_LOG   = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] q_nxt;
  logic          done_nxt;
  logic          dir_r, dir_r_nxt;
  logic [1:0]    mode_r, mode_r_nxt;

  // One position in the given direction; mode 11 falls through to rotate.
  function automatic logic [DW-1:0] step1(input logic [DW-1:0] v,
                                          input logic          d,
                                          input logic [1:0]    m);
    logic [DW-1:0] r;
    if (!d) begin
      if (m == MODE_LOG)        r = {1'b0, v[DW-1:1]};
      else if (m == MODE_ARITH) r = {v[DW-1], v[DW-1:1]};
      else                      r = {v[0], v[DW-1:1]};
    end else begin
      if (m == MODE_LOG || m == MODE_ARITH) r = {v[DW-2:0], 1'b0};
      else                                  r = {v[DW-2:0], v[DW-1]};
    end
    return r;
  endfunction

`ifdef UNIV_ROTATE_BARREL_EN
  // Equivalent of n single steps in one go. Rotation wraps modulo DW; shifts
  // by DW or more naturally saturate to zero / sign fill.
  function automatic logic [DW-1:0] barrel(input logic [DW-1:0] v,
                                           input logic [AW-1:0] n,
                                           input logic          d,
                                           input logic [1:0]    m);
    int unsigned   sh;
    int unsigned   rr;
    logic [2*DW-1:0] dbl;
    logic [2*DW-1:0] tmp;
    logic [DW-1:0]   r;
    sh  = 32'(n);
    rr  = sh % DW;
    dbl = {v, v};
    tmp = '0;
    if (!d) begin
      if (m == MODE_LOG) begin
        r = v >> sh;
      end else if (m == MODE_ARITH) begin
        r = $signed(v) >>> sh;
      end else begin
        tmp = dbl >> rr;
        r   = tmp[DW-1:0];
      end
    end else begin
      if (m == MODE_LOG || m == MODE_ARITH) begin
        r = v << sh;
      end else begin
        tmp = dbl << rr;
        r   = tmp[2*DW-1:DW];
      end
    end
    return r;
  endfunction
`endif

  assign busy = (state == ST_RUN);

  // Next-state and datapath: idle priority load > start > en; RUN steps with latched dir/mode until cnt hits zero.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    q_nxt      = q;
    done_nxt   = 1'b0;
    dir_r_nxt  = dir_r;
    mode_r_nxt = mode_r;
    case (state)
      ST_IDLE: begin
        if (load) begin
          q_nxt = data;
        end else if (start) begin
`ifdef UNIV_ROTATE_BARREL_EN
          q_nxt    = barrel(q, amt, dir, mode);
          done_nxt = 1'b1;
`else
          if (amt == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt  = ST_RUN;
            cnt_nxt    = amt;
            dir_r_nxt  = dir;
            mode_r_nxt = mode;
          end
`endif
        end else if (en) begin
          q_nxt = step1(q, dir, mode);
        end
      end
      ST_RUN: begin
        if (load) begin
          q_nxt     = data;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          q_nxt   = step1(q, dir_r, mode_r);
          cnt_nxt = cnt - 1'b1;
          if (cnt == AW'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset clears everything immediately, even mid-operation.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      q      <= '0;
      done   <= 1'b0;
      dir_r  <= 1'b0;
      mode_r <= 2'b00;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      q      <= q_nxt;
      done   <= done_nxt;
      dir_r  <= dir_r_nxt;
      mode_r <= mode_r_nxt;
    end
  end

endmodule
